// File: rtl/ahb_bus_pkg.sv
// Shared AHB-Lite bus definitions for the Cortex-M0 subsystem:
// transfer encodings, slave index map, region bounds and default-slave states.
package ahb_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Slave index order is fixed; HSEL_S bit i and HRDATA_S lane i follow it.
    typedef enum logic [2:0] {
        SEL_ROM     = 3'd0,
        SEL_RAM     = 3'd1,
        SEL_GPIO    = 3'd2,
        SEL_TIMER   = 3'd3,
        SEL_DEFAULT = 3'd4
    } slave_sel_e;

    // Inclusive region bounds.
    localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT   = 32'h0000_FFFF;
    localparam logic [31:0] RAM_BASE    = 32'h2000_0000;
    localparam logic [31:0] RAM_LIMIT   = 32'h2000_FFFF;
    localparam logic [31:0] GPIO_BASE   = 32'h4000_0000;
    localparam logic [31:0] GPIO_LIMIT  = 32'h4000_0FFF;
    localparam logic [31:0] TIMER_BASE  = 32'h4000_1000;
    localparam logic [31:0] TIMER_LIMIT = 32'h4000_1FFF;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dflt_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response, and idle/busy ones with a zero-wait OKAY.
module ahb_default_slave
    import ahb_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hready,
    input  logic start,
    output logic ready,
    output logic resp
);

    dflt_state_e state;
    dflt_state_e next_state;

    // State register; reset abandons any ERROR sequence in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= D_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An accepted active unmapped address phase starts (or restarts) the error pair.
    always_comb begin
        next_state = state;
        case (state)
            D_IDLE: begin
                if (hready && start) begin
                    next_state = D_ERR1;
                end
            end
            D_ERR1: begin
                next_state = D_ERR2;
            end
            D_ERR2: begin
                if (hready && start) begin
                    next_state = D_ERR1;
                end else begin
                    next_state = D_IDLE;
                end
            end
            default: begin
                next_state = D_IDLE;
            end
        endcase
    end

    // First error cycle stalls the master, second completes with ERROR.
    always_comb begin
        ready = 1'b1;
        resp  = 1'b0;
        case (state)
            D_ERR1: begin
                ready = 1'b0;
                resp  = 1'b1;
            end
            D_ERR2: begin
                ready = 1'b1;
                resp  = 1'b1;
            end
            default: begin
                ready = 1'b1;
                resp  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite decoder and response multiplexer: combinational
// address decode, registered data-phase select/address, default slave.
module ahb_lite_interconnect
    import ahb_bus_pkg::*;
#(
    parameter int NSLAVES = 4,
    parameter int DW      = 32,
    parameter int AW      = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [AW-1:0]         HADDR,
    input  logic [1:0]            HTRANS,
    output logic [NSLAVES-1:0]    HSEL_S,
    output logic [AW-1:0]         HADDR_DP,
    input  logic [NSLAVES*DW-1:0] HRDATA_S,
    input  logic [NSLAVES-1:0]    HREADYOUT_S,
    input  logic [NSLAVES-1:0]    HRESP_S,
    output logic [DW-1:0]         HRDATA,
    output logic                  HREADY,
    output logic                  HRESP
);

    slave_sel_e addr_sel;
    slave_sel_e sel_dp;
    logic       act_dp;
    logic       xfer_active;
    logic       unmapped_active;
    logic       dflt_ready;
    logic       dflt_resp;

    function automatic logic in_region(input logic [AW-1:0] a,
                                       input logic [AW-1:0] base,
                                       input logic [AW-1:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

    // Address-phase decode; slave select ignores HTRANS, slaves qualify it themselves.
    always_comb begin
        addr_sel = SEL_DEFAULT;
        if (in_region(HADDR, AW'(ROM_BASE), AW'(ROM_LIMIT))) begin
            addr_sel = SEL_ROM;
        end else if (in_region(HADDR, AW'(RAM_BASE), AW'(RAM_LIMIT))) begin
            addr_sel = SEL_RAM;
        end else if (in_region(HADDR, AW'(GPIO_BASE), AW'(GPIO_LIMIT))) begin
            addr_sel = SEL_GPIO;
        end else if (in_region(HADDR, AW'(TIMER_BASE), AW'(TIMER_LIMIT))) begin
            addr_sel = SEL_TIMER;
        end
        HSEL_S = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            HSEL_S[i] = (int'(addr_sel) == i);
        end
    end

    assign xfer_active     = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign unmapped_active = (addr_sel == SEL_DEFAULT) && xfer_active;

    // Data-phase registers advance only when the bus is ready; a stall holds them.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_dp   <= SEL_DEFAULT;
            act_dp   <= 1'b0;
            HADDR_DP <= '0;
        end else if (HREADY) begin
            sel_dp   <= addr_sel;
            act_dp   <= xfer_active;
            HADDR_DP <= HADDR;
        end
    end

    ahb_default_slave u_default_slave (
        .clk    (HCLK),
        .rst    (HRESET),
        .hready (HREADY),
        .start  (unmapped_active),
        .ready  (dflt_ready),
        .resp   (dflt_resp)
    );

    // Response mux keyed by the registered data-phase select; the default
    // slave only ever reports ERROR against an active data phase.
    always_comb begin
        HRDATA = '0;
        HREADY = dflt_ready;
        HRESP  = dflt_resp & act_dp;
        for (int i = 0; i < NSLAVES; i++) begin
            if (int'(sel_dp) == i) begin
                HRDATA = HRDATA_S[i*DW +: DW];
                HREADY = HREADYOUT_S[i];
                HRESP  = HRESP_S[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Self-checking bench for ahb_lite_interconnect: each cycle's expected
// outputs are queued as stimulus is driven and compared mid-cycle.
module tb_ahb_lite_interconnect;
    import ahb_bus_pkg::*;

    localparam int NSLAVES = 4;
    localparam int DW      = 32;
    localparam int AW      = 32;

    localparam logic [31:0] D_ROM   = 32'h0000_0800;
    localparam logic [31:0] D_RAM   = 32'hCAFE_0001;
    localparam logic [31:0] D_GPIO  = 32'h600D_0002;
    localparam logic [31:0] D_TIMER = 32'h71AE_0003;

    logic                  HCLK;
    logic                  HRESET;
    logic [AW-1:0]         HADDR;
    logic [1:0]            HTRANS;
    logic [NSLAVES-1:0]    HSEL_S;
    logic [AW-1:0]         HADDR_DP;
    logic [NSLAVES*DW-1:0] HRDATA_S;
    logic [NSLAVES-1:0]    HREADYOUT_S;
    logic [NSLAVES-1:0]    HRESP_S;
    logic [DW-1:0]         HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    typedef struct {
        int          step;
        logic [3:0]  hsel;
        logic        ready;
        logic        resp;
        logic [31:0] rdata;
        logic [31:0] addr_dp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_num = 0;

    ahb_lite_interconnect #(
        .NSLAVES (NSLAVES),
        .DW      (DW),
        .AW      (AW)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL_S      (HSEL_S),
        .HADDR_DP    (HADDR_DP),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Called just after a rising edge: drives one cycle, queues its expected
    // outputs, compares them at the falling edge, returns after the next rise.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                                 input logic [3:0] rdy, input logic [3:0] rsp,
                                 input logic [3:0] e_hsel, input logic e_ready, input logic e_resp,
                                 input logic [31:0] e_rdata, input logic [31:0] e_addr_dp);
        exp_t e;
        exp_t got;
        step_num++;
        HADDR       = addr;
        HTRANS      = trans;
        HREADYOUT_S = rdy;
        HRESP_S     = rsp;
        e.step    = step_num;
        e.hsel    = e_hsel;
        e.ready   = e_ready;
        e.resp    = e_resp;
        e.rdata   = e_rdata;
        e.addr_dp = e_addr_dp;
        sb_q.push_back(e);
        @(negedge HCLK);
        got = sb_q.pop_front();
        checkOutput($sformatf("s%0d_hsel", got.step), {28'b0, HSEL_S}, {28'b0, got.hsel});
        checkOutput($sformatf("s%0d_hready", got.step), {31'b0, HREADY}, {31'b0, got.ready});
        checkOutput($sformatf("s%0d_hresp", got.step), {31'b0, HRESP}, {31'b0, got.resp});
        checkOutput($sformatf("s%0d_hrdata", got.step), HRDATA, got.rdata);
        checkOutput($sformatf("s%0d_haddr_dp", got.step), HADDR_DP, got.addr_dp);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        HRESET      = 1'b1;
        HADDR       = '0;
        HTRANS      = HTRANS_IDLE;
        HRDATA_S    = {D_TIMER, D_GPIO, D_RAM, D_ROM};
        HREADYOUT_S = 4'b1111;
        HRESP_S     = 4'b0000;

        repeat (2) @(negedge HCLK);
        checkOutput("rst_hready", {31'b0, HREADY}, 32'd1);
        checkOutput("rst_hresp", {31'b0, HRESP}, 32'd0);
        checkOutput("rst_hrdata", HRDATA, 32'd0);
        checkOutput("rst_haddr_dp", HADDR_DP, 32'd0);
        @(posedge HCLK);
        #2;
        HRESET = 1'b0;

        //              addr           trans          rdy      rsp      hsel     rdy   rsp   rdata    addr_dp
        applyStimulus(32'h0000_FFFF, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h0,   32'h0);
        applyStimulus(32'h0000_0008, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, D_ROM,   32'h0000_FFFF);
        applyStimulus(32'h2000_0004, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, D_ROM,   32'h0000_0008);
        applyStimulus(32'h6000_0000, HTRANS_IDLE,   4'b1101, 4'b0000, 4'b0000, 1'b0, 1'b0, D_RAM,   32'h2000_0004);
        applyStimulus(32'h6000_0000, HTRANS_IDLE,   4'b1101, 4'b0000, 4'b0000, 1'b0, 1'b0, D_RAM,   32'h2000_0004);
        applyStimulus(32'h6000_0000, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, D_RAM,   32'h2000_0004);
        applyStimulus(32'h6000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h0,   32'h6000_0000);
        applyStimulus(32'h6000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0,   32'h6000_0000);
        applyStimulus(32'h6000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0,   32'h6000_0000);
        applyStimulus(32'h0000_0008, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1, 32'h0,   32'h6000_0000);
        applyStimulus(32'h0000_0008, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b1, 32'h0,   32'h6000_0000);
        applyStimulus(32'h0000_0000, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, D_ROM,   32'h0000_0008);
        applyStimulus(32'h4000_0FFF, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, D_ROM,   32'h0000_0000);
        applyStimulus(32'h4000_1000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, D_GPIO,  32'h4000_0FFF);
        applyStimulus(32'h2000_FFFF, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0, D_TIMER, 32'h4000_1000);
        applyStimulus(32'h0001_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, D_RAM,   32'h2000_FFFF);
        applyStimulus(32'h4000_2000, HTRANS_SEQ,    4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0,   32'h0001_0000);
        applyStimulus(32'h4000_2000, HTRANS_SEQ,    4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0,   32'h0001_0000);
        applyStimulus(32'h1FFF_FFFF, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0,   32'h4000_2000);
        applyStimulus(32'h1FFF_FFFF, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'h0,   32'h4000_2000);
        applyStimulus(32'h4000_0000, HTRANS_BUSY,   4'b1111, 4'b0000, 4'b0100, 1'b1, 1'b0, 32'h0,   32'h1FFF_FFFF);
        applyStimulus(32'h4000_1FFC, HTRANS_IDLE,   4'b1011, 4'b0100, 4'b1000, 1'b0, 1'b1, D_GPIO,  32'h4000_0000);
        applyStimulus(32'h4000_1FFC, HTRANS_IDLE,   4'b1111, 4'b0100, 4'b1000, 1'b1, 1'b1, D_GPIO,  32'h4000_0000);
        applyStimulus(32'h6000_0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, D_TIMER, 32'h4000_1FFC);

        // Now in the first ERROR cycle; pulse reset asynchronously mid-cycle.
        @(negedge HCLK);
        checkOutput("err1_hready", {31'b0, HREADY}, 32'd0);
        checkOutput("err1_hresp", {31'b0, HRESP}, 32'd1);
        #2;
        HRESET = 1'b1;
        #1;
        checkOutput("arst_hready", {31'b0, HREADY}, 32'd1);
        checkOutput("arst_hresp", {31'b0, HRESP}, 32'd0);
        checkOutput("arst_hrdata", HRDATA, 32'd0);
        checkOutput("arst_haddr_dp", HADDR_DP, 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        applyStimulus(32'h0000_0000, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h0,   32'h0);
        applyStimulus(32'h6000_0000, HTRANS_IDLE,   4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, D_ROM,   32'h0);

        checkOutput("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_lite_interconnect.md
Name: ahb_lite_interconnect

Overview:
- Single-master AHB-Lite decoder and read-data/response multiplexer for the Cortex-M0 subsystem.
- Sits between the core bus and the slaves (ROM, RAM, GPIO, timer):
  - drives each slave's HSEL;
  - supplies a registered data-phase address for combinational-read slaves such as the boot ROM;
  - returns the selected slave's HRDATA/HREADY/HRESP to the master.
- Contains the default slave, which gives the two-cycle ERROR response for unmapped accesses.

Parameters:
- NSLAVES, 4, number of mapped slaves; index order is fixed by the shared package map.
- DW, 32, data width.
- AW, 32, address width.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous active-high reset.
- HADDR  in  AW  master address, address phase.
- HTRANS  in  2  master transfer type; bit1=1 means NONSEQ/SEQ.
- HSEL_S  out  NSLAVES  one-hot slave select, combinational from HADDR.
- HADDR_DP  out  AW  registered data-phase address for combinational slaves.
- HRDATA_S  in  NSLAVES*DW  packed slave read data; slave i occupies bits [i*DW +: DW].
- HREADYOUT_S  in  NSLAVES  slave ready; tied 1 for zero-wait slaves such as the ROM.
- HRESP_S  in  NSLAVES  slave error response.
- HRDATA  out  DW  read data to master.
- HREADY  out  1  combined ready to master and to all slaves.
- HRESP  out  1  combined response to master.

Behaviour:
- Memory map (package constants, region match on HADDR):
  - slave0 ROM 0x0000_0000–0x0000_FFFF
  - slave1 RAM 0x2000_0000–0x2000_FFFF
  - slave2 GPIO 0x4000_0000–0x4000_0FFF
  - slave3 TIMER 0x4000_1000–0x4000_1FFF
  - any other address → DEFAULT.
- Address-phase decode is combinational. HSEL_S is driven from HADDR regardless of HTRANS; slaves qualify with HTRANS[1] & HREADY. For an unmapped address, HSEL_S = 0.
- Data-phase capture happens on HCLK rising when HREADY=1:
  - sel_dp ← decoded index (0..NSLAVES-1 or DEFAULT);
  - act_dp ← HTRANS[1];
  - HADDR_DP ← HADDR.
- When HREADY=0, all three registers hold; the master is holding its address phase.
- Data-phase mux:
  - sel_dp = i: HRDATA = HRDATA_S[i], HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
  - sel_dp = DEFAULT: HRDATA = 0; HREADY and HRESP come from the default-slave FSM.
- Default-slave FSM states: D_IDLE, D_ERR1, D_ERR2.
  - D_IDLE → D_ERR1 on an edge with HREADY=1, decode=DEFAULT, HTRANS[1]=1.
  - D_ERR1: HREADY=0, HRESP=1. Always → D_ERR2 next cycle.
  - D_ERR2: HREADY=1, HRESP=1.
    - → D_ERR1 if the pipelined address phase is another active unmapped transfer.
    - Otherwise → D_IDLE.
  - D_IDLE with sel_dp=DEFAULT, i.e. an IDLE/BUSY transfer to an unmapped address: HREADY=1, HRESP=0 (zero-wait OKAY).
- Reset, asynchronous, immediate:
  - sel_dp = DEFAULT, act_dp = 0, HADDR_DP = 0, FSM = D_IDLE.
  - Hence HREADY=1, HRESP=0, HRDATA=0.
  - Reset asserted mid-wait-state or mid-ERROR aborts the transfer; no response is completed.
- Slave wait states: HREADYOUT_S[i]=0 in the data phase stalls capture. A new address held during the stall is decoded, but it is not registered until HREADY=1.
- Latency: zero added cycles. Decode is combinational and the response mux is combinational from the sel_dp register.
- ERROR from a mapped slave (HRESP_S[i]) is passed through unmodified; the slave owns its two-cycle sequencing.
- Region match uses unsigned compares on the full AW bits. Region boundaries are inclusive.

Decomposition:
- Package ahb_bus_pkg holds:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - slave index enum including SEL_DEFAULT;
  - region base/limit constants;
  - default-slave state typedef.
- Sub-module ahb_default_slave: the 3-state FSM, producing HREADYOUT/HRESP for DEFAULT.

Test Plan:
- Reset released, no traffic, HTRANS=IDLE → HREADY=1, HRESP=0, HRDATA=0, HADDR_DP=0.
- NONSEQ read to 0x0000_0008, ROM (slave0) returns 0x00000800 → HSEL_S=4'b0001 in the address phase; next cycle HADDR_DP=0x0000_0008, HRDATA=0x00000800, HREADY=1.
- NONSEQ to 0x2000_0004, RAM holds HREADYOUT_S[1]=0 for 2 cycles → HREADY low 2 cycles, HADDR_DP stays 0x2000_0004, data delivered on the 3rd cycle.
- NONSEQ to 0x6000_0000 (unmapped) → HSEL_S=0; cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1, then OKAY. IDLE to the same address → zero-wait OKAY.
- Back-to-back unmapped NONSEQ, then ROM NONSEQ → ERR1, ERR2, ERR1, ERR2, then ROM data with HRESP=0; ROM address captured only on HREADY=1 edges.
- HRESET pulsed during D_ERR1 → HREADY=1, HRESP=0 immediately (asynchronous); FSM = D_IDLE after release.
